// File: rtl/cmos_capture_pkg.sv
// Shared types and defaults for the CMOS RGB565 capture block.
package cmos_capture_pkg;

    localparam int RGB_W           = 16;
    localparam int DEF_H_PIXELS    = 480;
    localparam int DEF_V_LINES     = 272;
    localparam int DEF_SKIP_FRAMES = 10;

    typedef enum logic [1:0] {
        WAIT_INIT,
        WAIT_VS,
        SKIP,
        CAPTURE
    } cap_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cmos_capture_rgb565.sv
// Pairs CMOS sensor bytes into RGB565 words and forwards whole frames to the
// frame-buffer write FIFO once SDRAM is ready and the sensor has settled.
module cmos_capture_rgb565
    import cmos_capture_pkg::*;
#(
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int SKIP_FRAMES = DEF_SKIP_FRAMES
) (
    input  logic             cam_pclk,
    input  logic             rst_n,
    input  logic             sdram_init_done,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    output logic             sys_we,
    output logic [RGB_W-1:0] sys_data_in,
    output logic             frame_valid,
    output logic             frame_done,
    output logic             err_line,
    output logic             err_frame
);

    localparam int SKIP_W = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);

    logic              rst_sync_n;
    logic              init_ok;
    logic              vs_s0, href_s0, vs_d, href_d;
    logic [7:0]        data_s0, hi_byte;
    logic              hi_pending, in_frame;
    logic [10:0]       pix_cnt;
    logic [9:0]        line_cnt, line_cnt_closed;
    logic [SKIP_W-1:0] skip_cnt;
    logic              frame_start, frame_end, href_rise, href_fall;
    logic              line_open, frame_close;
    cap_state_t        state, state_next;

    // Reset is released synchronously so every register leaves reset on the same edge.
    sync_2ff u_rst_sync (.clk(cam_pclk), .rst_n(rst_n), .d(1'b1), .q(rst_sync_n));
    sync_2ff u_init_sync (.clk(cam_pclk), .rst_n(rst_sync_n), .d(sdram_init_done), .q(init_ok));

    assign frame_start     = vs_d & ~vs_s0;
    assign frame_end       = ~vs_d & vs_s0;
    assign href_rise       = href_s0 & ~href_d;
    assign href_fall       = href_d & ~href_s0;
    assign line_open       = (state == CAPTURE) && in_frame && (line_cnt < 10'(V_LINES));
    assign frame_close     = (state == CAPTURE) && in_frame && frame_end;
    // A line closing in the same cycle as the frame still counts toward that frame.
    assign line_cnt_closed = (href_fall && line_cnt != 10'h3FF) ? line_cnt + 10'd1 : line_cnt;

    always_ff @(posedge cam_pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= WAIT_INIT;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_INIT: if (init_ok) state_next = WAIT_VS;
            WAIT_VS:   if (frame_start) state_next = (SKIP_FRAMES == 0) ? CAPTURE : SKIP;
            SKIP:      if (frame_start && skip_cnt == SKIP_W'(SKIP_FRAMES)) state_next = CAPTURE;
            CAPTURE:   state_next = CAPTURE;
            default:   state_next = WAIT_INIT;
        endcase
        if (!init_ok) state_next = WAIT_INIT;
    end

    always_ff @(posedge cam_pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            vs_s0    <= 1'b0;
            href_s0  <= 1'b0;
            data_s0  <= 8'h00;
            vs_d     <= 1'b0;
            href_d   <= 1'b0;
            in_frame <= 1'b0;
            skip_cnt <= '0;
            line_cnt <= 10'd0;
        end else begin
            vs_s0   <= cam_vsync;
            href_s0 <= cam_href;
            data_s0 <= cam_data;
            vs_d    <= vs_s0;
            href_d  <= href_s0;
            if (frame_start)    in_frame <= 1'b1;
            else if (frame_end) in_frame <= 1'b0;
            if (state == WAIT_VS)
                skip_cnt <= '0;
            else if (state == SKIP && frame_end && skip_cnt != SKIP_W'(SKIP_FRAMES))
                skip_cnt <= skip_cnt + 1'b1;
            line_cnt <= frame_start ? 10'd0 : line_cnt_closed;
        end
    end

    // Even bytes are parked as the high half; each odd byte completes a pixel.
    always_ff @(posedge cam_pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            hi_byte     <= 8'h00;
            hi_pending  <= 1'b0;
            pix_cnt     <= 11'd0;
            sys_we      <= 1'b0;
            sys_data_in <= '0;
            err_line    <= 1'b0;
        end else begin
            sys_we <= 1'b0;
            if (href_rise) begin
                pix_cnt    <= 11'd0;
                hi_byte    <= data_s0;
                hi_pending <= 1'b1;
            end else if (href_s0) begin
                if (hi_pending) begin
                    hi_pending <= 1'b0;
                    if (line_open && pix_cnt < 11'(H_PIXELS)) begin
                        sys_we      <= 1'b1;
                        sys_data_in <= {hi_byte, data_s0};
                    end
                    if (pix_cnt != 11'h7FF) pix_cnt <= pix_cnt + 11'd1;
                end else begin
                    hi_byte    <= data_s0;
                    hi_pending <= 1'b1;
                end
            end else if (href_fall) begin
                hi_pending <= 1'b0;
                if (hi_pending || (line_open && pix_cnt < 11'(H_PIXELS)))
                    err_line <= 1'b1;
            end
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            frame_valid <= (state_next == CAPTURE);
            frame_done  <= frame_close;
            if (frame_close && line_cnt_closed != 10'(V_LINES))
                err_frame <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Randomised frame-level bench for cmos_capture_rgb565 with a queue-based
// reference model of which pixels each frame should deliver.
module tb_cmos_capture_rgb565;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int SKIPN = 2;

    logic        cam_pclk        = 1'b0;
    logic        rst_n           = 1'b1;
    logic        sdram_init_done = 1'b0;
    logic        cam_vsync       = 1'b1;
    logic        cam_href        = 1'b0;
    logic [7:0]  cam_data        = 8'h00;
    logic        sys_we;
    logic [15:0] sys_data_in;
    logic        frame_valid, frame_done, err_line, err_frame;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_word   = 16'h0000;
    int          done_seen   = 0;
    int          done_exp    = 0;
    bit          err_line_exp  = 1'b0;
    bit          err_frame_exp = 1'b0;
    bit          armed         = 1'b0;
    int          frames_armed  = 0;
    bit          cap           = 1'b0;
    int          line_idx      = 0;

    cmos_capture_rgb565 #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SKIPN)) dut (
        .cam_pclk        (cam_pclk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .cam_vsync       (cam_vsync),
        .cam_href        (cam_href),
        .cam_data        (cam_data),
        .sys_we          (sys_we),
        .sys_data_in     (sys_data_in),
        .frame_valid     (frame_valid),
        .frame_done      (frame_done),
        .err_line        (err_line),
        .err_frame       (err_frame)
    );

    always #5 cam_pclk = ~cam_pclk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    always @(posedge cam_pclk) begin
        #1;
        if (frame_done === 1'b1) done_seen++;
        if (sys_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checkOutput("stray_write", {31'd0, sys_we}, 32'd0);
            end else begin
                last_word = exp_q.pop_front();
                checkOutput("pixel_word", {16'd0, sys_data_in}, {16'd0, last_word});
            end
        end else begin
            checkOutput("data_hold", {16'd0, sys_data_in}, {16'd0, last_word});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge cam_pclk);
    endtask

    task automatic frameStart();
        @(negedge cam_pclk);
        cam_vsync = 1'b0;
        if (armed) frames_armed++;
        cap      = armed && (frames_armed > SKIPN);
        line_idx = 0;
        tick(4);
        checkOutput("frame_valid", {31'd0, frame_valid}, {31'd0, cap});
    endtask

    task automatic sendLine(input int nbytes, input bit close_vs);
        logic [7:0] b[$];
        for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom));
        if (nbytes % 2 != 0) err_line_exp = 1'b1;
        if (cap && line_idx < V) begin
            if (nbytes / 2 < H) err_line_exp = 1'b1;
            for (int p = 0; p < nbytes / 2 && p < H; p++)
                exp_q.push_back({b[2*p], b[2*p+1]});
        end
        line_idx++;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge cam_pclk);
            cam_href = 1'b1;
            cam_data = b[i];
        end
        @(negedge cam_pclk);
        cam_href = 1'b0;
        cam_data = 8'($urandom);
        if (close_vs) cam_vsync = 1'b1;
        tick(2);
    endtask

    task automatic frameEnd();
        @(negedge cam_pclk);
        cam_vsync = 1'b1;
        if (cap) begin
            done_exp++;
            if (line_idx != V) err_frame_exp = 1'b1;
        end
        cap = 1'b0;
        tick(5);
        checkOutput("frame_done_count", done_seen, done_exp);
        checkOutput("missing_writes", exp_q.size(), 0);
        checkOutput("err_line", {31'd0, err_line}, {31'd0, err_line_exp});
        checkOutput("err_frame", {31'd0, err_frame}, {31'd0, err_frame_exp});
    endtask

    task automatic applyStimulus(input int nlines, input int nbytes, input int odd_line,
                                 input int odd_bytes, input bit close_vs);
        frameStart();
        for (int l = 0; l < nlines; l++)
            sendLine((l == odd_line) ? odd_bytes : nbytes, close_vs && (l == nlines - 1));
        frameEnd();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sys_we"},      {31'd0, sys_we},      32'd0);
        checkOutput({tag, "_sys_data_in"}, {16'd0, sys_data_in}, 32'd0);
        checkOutput({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
        checkOutput({tag, "_frame_done"},  {31'd0, frame_done},  32'd0);
        checkOutput({tag, "_err_line"},    {31'd0, err_line},    32'd0);
        checkOutput({tag, "_err_frame"},   {31'd0, err_frame},   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pb[$];

        #2 rst_n = 1'b0;
        tick(3);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        tick(4);

        $display("[TB] init held low for 5 frames");
        repeat (5) applyStimulus(V, 2 * H, -1, 0, 1'b0);

        sdram_init_done = 1'b1;
        armed = 1'b1;
        frames_armed = 0;
        tick(6);

        $display("[TB] skip frames, then clean captured frames");
        repeat (SKIPN) applyStimulus(V, 2 * H, -1, 0, 1'b0);
        applyStimulus(V, 2 * H, -1, 0, 1'b0);
        applyStimulus(V, 2 * H, -1, 0, 1'b1);
        applyStimulus(V, 2 * H, -1, 0, 1'b0);

        $display("[TB] odd-length line and oversized frame");
        applyStimulus(V, 2 * H, 2, 2 * H + 1, 1'b0);
        applyStimulus(V + 2, 2 * H + 2 * int'($urandom_range(1, 4)), -1, 0, 1'b0);

        $display("[TB] init loss during capture");
        frameStart();
        sendLine(2 * H, 1'b0);
        sendLine(2 * H, 1'b0);
        @(negedge cam_pclk);
        sdram_init_done = 1'b0;
        armed = 1'b0;
        frames_armed = 0;
        cap = 1'b0;
        repeat (3) @(posedge cam_pclk);
        #1 checkOutput("frame_valid_drop", {31'd0, frame_valid}, 32'd0);
        sendLine(2 * H, 1'b0);
        sendLine(2 * H, 1'b0);
        frameEnd();
        sdram_init_done = 1'b1;
        armed = 1'b1;
        tick(6);
        repeat (SKIPN) applyStimulus(V, 2 * H, -1, 0, 1'b0);
        applyStimulus(V, 2 * H, -1, 0, 1'b0);

        $display("[TB] reset mid-line during capture");
        frameStart();
        sendLine(2 * H, 1'b0);
        for (int i = 0; i < 5; i++) pb.push_back(8'($urandom));
        exp_q.push_back({pb[0], pb[1]});
        exp_q.push_back({pb[2], pb[3]});
        for (int i = 0; i < 5; i++) begin
            @(negedge cam_pclk);
            cam_href = 1'b1;
            cam_data = pb[i];
        end
        @(negedge cam_pclk);
        checkOutput("writes_before_reset", exp_q.size(), 0);
        rst_n = 1'b0;
        last_word = 16'h0000;
        #1 checkResetOutputs("midline_reset");
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        frames_armed  = 0;
        cap           = 1'b0;
        err_line_exp  = 1'b0;
        err_frame_exp = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(8);
        repeat (SKIPN) applyStimulus(V, 2 * H, -1, 0, 1'b0);

        $display("[TB] short line and short frame after reset");
        applyStimulus(V, 2 * H, 1, 2 * H - 4, 1'b0);
        applyStimulus(V - 1, 2 * H, -1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmos_capture_rgb565.md
CMOS_CAPTURE_RGB565 -- requirements
Module: cmos_capture_rgb565

Interface
REQ-001 SHALL have parameter H_PIXELS, default 480: RGB565 pixels written per line.
REQ-002 SHALL have parameter V_LINES, default 272: lines written per frame (480*272 = 130560 words).
REQ-003 SHALL have parameter SKIP_FRAMES, default 10: complete frames discarded after init while the sensor settles.
REQ-004 cam_pclk  input  1  sensor pixel clock; every register in the block uses this clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sdram_init_done  input  1  SDRAM ready, from the clk_ref domain, asynchronous to cam_pclk.
REQ-007 cam_vsync  input  1  sensor vertical sync, high during vertical blanking.
REQ-008 cam_href  input  1  sensor line valid, active high.
REQ-009 cam_data  input  8  sensor byte bus.
REQ-010 sys_we  output  1  one-cycle write strobe to the frame-buffer write FIFO.
REQ-011 sys_data_in  output  16  RGB565 word, valid while sys_we=1.
REQ-012 frame_valid  output  1  level, high while frames are being forwarded (drives bank-switch enable).
REQ-013 frame_done  output  1  one-cycle pulse at the end of each forwarded frame.
REQ-014 err_line  output  1  sticky flag: odd byte count or short line seen.
REQ-015 err_frame  output  1  sticky flag: forwarded frame line count differed from V_LINES.

Function
REQ-016 SHALL register cam_vsync, cam_href and cam_data once on entry (stage S0) before any decoding.
REQ-017 SHALL synchronise sdram_init_done through a 2-flop synchroniser before use.
REQ-018 Frame start SHALL be the falling edge of registered vsync; frame end SHALL be its rising edge.
REQ-019 SHALL implement FSM states WAIT_INIT, WAIT_VS, SKIP, CAPTURE.
REQ-020 WAIT_INIT -> WAIT_VS when the synchronised init_done is 1.
REQ-021 WAIT_VS -> SKIP at the next frame start, skip counter cleared; -> CAPTURE instead if SKIP_FRAMES=0.
REQ-022 SKIP: increment the counter at each frame end; -> CAPTURE at the frame start following SKIP_FRAMES frame ends.
REQ-023 CAPTURE stays in CAPTURE until reset; a low synchronised init_done SHALL force the FSM to WAIT_INIT and clear frame_valid.
REQ-024 Within a line, even-indexed bytes (0, 2, ...) are the high byte {R[4:0],G[5:3]} and odd-indexed bytes are the low byte {G[2:0],B[4:0]}.
REQ-025 sys_we SHALL pulse in the cycle after the S0 register holds the low byte; sys_data_in = {high, low} in that same cycle.
REQ-026 Total latency: 2 cam_pclk cycles from low-byte sampling at the pin to sys_we high.
REQ-027 sys_we SHALL be driven only in CAPTURE, within a frame, with the line index < V_LINES and the pixel index < H_PIXELS; surplus pixels and lines are dropped silently.
REQ-028 Pixel counter (11 bits) clears at href rise; line counter (10 bits) increments at href fall and clears at frame start.
REQ-029 On href fall with an odd byte count, the dangling high byte SHALL be discarded and err_line set.
REQ-030 On href fall with fewer than H_PIXELS pixels in a captured line, err_line SHALL be set; no padding is written.
REQ-031 At a frame end in CAPTURE: frame_done pulses for 1 cycle; err_frame is set if the line count != V_LINES.
REQ-032 frame_valid SHALL rise at the first CAPTURE frame start and stay high until reset or init loss.
REQ-033 If a vsync edge and an href edge occur in the same cycle, the vsync edge takes precedence: the line closes, then the frame closes.
REQ-034 sys_data_in SHALL hold its last value when sys_we=0.

Reset
REQ-035 Asynchronous assertion and synchronous de-assertion, applied to all registers.
REQ-036 Reset values: FSM=WAIT_INIT; sys_we=0; sys_data_in=0; frame_valid=0; frame_done=0; err_line=0; err_frame=0; all counters=0.
REQ-037 Reset mid-frame SHALL drop the partial frame; the skip sequence restarts and no write occurs before a fresh frame start.

Structure
REQ-038 Package cmos_capture_pkg SHALL hold the FSM state enum, the RGB565 width constant (16) and the default H_PIXELS, V_LINES and SKIP_FRAMES values.
REQ-039 The 2-flop synchroniser SHALL be a separate sub-module sync_2ff (1 bit, async active-low reset, reset value 0).

Verification
REQ-040 Init held low for 5 frames, then high; SKIP_FRAMES=2 -> zero sys_we until the 3rd complete frame start after init; then frame_valid=1.
REQ-041 Full 480x272 frame, bytes 0xF8,0x1F repeated -> exactly 130560 sys_we pulses, each with data 0xF81F; frame_done pulses once; err flags remain 0.
REQ-042 One line with 961 bytes -> 480 writes, last byte dropped, err_line=1.
REQ-043 Frame with 275 lines of 500 pixels -> 130560 writes total, err_frame=1 at frame end.
REQ-044 rst_n pulsed low mid-line during CAPTURE -> all outputs at reset values immediately; no sys_we until a new frame start plus SKIP_FRAMES frames.
REQ-045 sdram_init_done drops during CAPTURE -> frame_valid=0 within 3 cam_pclk cycles; writes stop; FSM returns to WAIT_INIT.
